// File: rtl/load_data_unit.sv
// Load data unit: issues one aligned word read for a RISC-V load, then
// extracts and sign/zero-extends the requested byte, half or word.
// Misaligned accesses and illegal funct3 codes complete immediately with err
// set and never touch memory.
module load_data_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // Flags funct3 codes that are not loads, and loads whose width does not
  // fit inside one aligned word at the given byte offset.
  function automatic logic bad_access(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Picks the addressed byte lane / half-word lane and extends it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = 8'h00;
    res    = 32'h0000_0000;
    case (off)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b100:  res = {24'h00_0000, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b101:  res = {16'h0000, half_v};
      3'b010:  res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  state_t      state_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic        load_start_s;
  logic        bad_s;
  logic        unused_inst_s;

  // Decode an incoming issue request: only load opcodes are accepted.
  always_comb begin
    load_start_s  = 1'b0;
    bad_s         = 1'b0;
    unused_inst_s = ^{inst[31:15], inst[11:7]};
    if (start && (inst[6:0] == OPC_LOAD)) begin
      load_start_s = 1'b1;
      bad_s        = bad_access(inst[14:12], addr[1:0]);
    end else begin
      load_start_s = 1'b0;
      bad_s        = 1'b0;
    end
  end

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      funct3_r <= 3'b000;
      off_r    <= 2'b00;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0000_0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= 32'h0000_0000;
      err      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_start_s) begin
            funct3_r <= inst[14:12];
            off_r    <= addr[1:0];
            busy     <= 1'b1;
            if (bad_s) begin
              // Rejected access: report straight away, memory untouched.
              state_r <= ST_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              rd_data <= 32'h0000_0000;
            end else begin
              state_r  <= ST_REQ;
              mem_req  <= 1'b1;
              mem_addr <= {addr[31:2], 2'b00};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Request and address stay frozen until the memory grants.
          if (mem_gnt) begin
            state_r  <= ST_WAIT;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0000_0000;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            err     <= 1'b0;
            rd_data <= extract_load(funct3_r, off_r, mem_rdata);
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // rd_data and err keep their values until the next completion.
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_req  <= 1'b0;
          mem_addr <= 32'h0000_0000;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_unit.sv
// Directed self-checking bench for load_data_unit.
module tb_load_data_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] inst;
  logic [31:0] addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        done;
  logic [31:0] rd_data;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] WORD = 32'hA5F0_B376;

  load_data_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .inst       (inst),
    .addr       (addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_load(input logic [2:0] f3);
    return {17'h0, f3, 5'h0, 7'b0000011};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; inst = 32'h0; addr = 32'h0;
    mem_gnt = 1'b0; mem_rdata = 32'h0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, busy, done, err} !== 4'b0000 || mem_addr !== 32'h0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset: req=%b busy=%b done=%b err=%b addr=%h data=%h expected all zero",
               mem_req, busy, done, err, mem_addr, rd_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issues one load and plays the memory side: grant after gdly REQ cycles,
  // rvalid after rdly further WAIT cycles. Cycle n is the n-th cycle after
  // the edge that samples start.
  task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input int gdly, input int rdly, input bit junk, input bit spam,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    int  gcnt = 0;
    int  rcnt = 0;
    bit  granted = 0;
    bit  rv_sent = 0;
    bit  saw_req = 0;
    bit  addr_bad = 0;
    int  done_cnt = 0;
    int  lat = -1;
    logic busy1 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; inst = mk_load(f3); addr = a;
    @(posedge clk); #1;
    start = 1'b0; inst = 32'h0; addr = 32'h0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 1) busy1 = busy;
      if (mem_req) begin
        saw_req = 1;
        if (mem_addr !== {a[31:2], 2'b00}) addr_bad = 1;
      end else if (mem_addr !== 32'h0) begin
        addr_bad = 1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) lat = cyc;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h1234_5678;
      if (spam && cyc <= 2) begin
        start = 1'b1; inst = mk_load(3'b010); addr = 32'h0000_2000;
      end else begin
        start = 1'b0; inst = 32'h0; addr = 32'h0;
      end
      if (mem_req && !granted) begin
        if (gcnt == gdly) begin
          mem_gnt = 1'b1; granted = 1;
        end else begin
          gcnt++;
          if (junk) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
          end
        end
      end else if (granted && !rv_sent) begin
        if (rcnt == rdly) begin
          mem_rvalid = 1'b1; mem_rdata = WORD; rv_sent = 1;
        end else begin
          rcnt++;
        end
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", nm, busy1);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d expected 1", nm, done_cnt);
    end
    checks++;
    if (rd_data !== exp_d) begin
      errors++; $display("FAIL %s rd_data: got %h expected %h", nm, rd_data, exp_d);
    end
    checks++;
    if (err !== exp_e) begin
      errors++; $display("FAIL %s err: got %b expected %b", nm, err, exp_e);
    end
    checks++;
    if (saw_req != !exp_e) begin
      errors++; $display("FAIL %s mem_req_seen: got %0d expected %0d", nm, saw_req, !exp_e);
    end
    checks++;
    if (addr_bad || busy !== 1'b0) begin
      errors++; $display("FAIL %s addr_stable_idle: addr_bad=%0d busy=%b expected 0/0", nm, addr_bad, busy);
    end
  endtask

  task automatic test_loads();
    run_load("lb_1003",  3'b000, 32'h1003, 0, 0, 0, 0, 32'hFFFF_FFA5, 1'b0, 3);
    run_load("lbu_1000", 3'b100, 32'h1000, 0, 0, 0, 0, 32'h0000_0076, 1'b0, 3);
    run_load("lhu_1000", 3'b101, 32'h1000, 0, 0, 0, 0, 32'h0000_B376, 1'b0, 3);
    run_load("lh_1002",  3'b001, 32'h1002, 0, 0, 0, 0, 32'hFFFF_A5F0, 1'b0, 3);
    run_load("lw_1000",  3'b010, 32'h1000, 0, 0, 0, 0, 32'hA5F0_B376, 1'b0, 3);
    run_load("lb_1001",  3'b000, 32'h1001, 0, 0, 0, 0, 32'hFFFF_FFB3, 1'b0, 3);
    run_load("lbu_1002", 3'b100, 32'h1002, 0, 0, 0, 0, 32'h0000_00F0, 1'b0, 3);
  endtask

  task automatic test_errors();
    run_load("lw_1002",  3'b010, 32'h1002, 0, 0, 0, 0, 32'h0, 1'b1, 1);
    run_load("lbu_1003", 3'b100, 32'h1003, 0, 0, 0, 0, 32'h0000_00A5, 1'b0, 3);
    run_load("lh_1001",  3'b001, 32'h1001, 0, 0, 0, 0, 32'h0, 1'b1, 1);
    run_load("lw_1000b", 3'b010, 32'h1000, 0, 0, 0, 0, 32'hA5F0_B376, 1'b0, 3);
    run_load("f3_011",   3'b011, 32'h1000, 0, 0, 0, 0, 32'h0, 1'b1, 1);
    run_load("f3_111",   3'b111, 32'h1000, 0, 0, 0, 0, 32'h0, 1'b1, 1);
  endtask

  task automatic test_stall();
    run_load("stall_lhu", 3'b101, 32'h1002, 4, 1, 1, 0, 32'h0000_A5F0, 1'b0, 8);
  endtask

  task automatic test_back_to_back();
    // Store opcode in IDLE must be ignored.
    bit moved = 0;
    @(posedge clk); #1;
    start = 1'b1; inst = {17'h0, 3'b010, 5'h0, 7'b0100011}; addr = 32'h1000;
    @(posedge clk); #1;
    start = 1'b0; inst = 32'h0; addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) moved = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (moved) begin
      errors++; $display("FAIL store_ignored: DUT left IDLE, expected no activity");
    end
    // Start pulses while busy must not create a second transaction.
    run_load("busy_start", 3'b100, 32'h1001, 0, 0, 0, 1, 32'h0000_00B3, 1'b0, 3);
  endtask

  task automatic test_abort();
    bit leak = 0;
    @(posedge clk); #1;
    start = 1'b1; inst = mk_load(3'b010); addr = 32'h1000;
    @(posedge clk); #1;
    start = 1'b0; inst = 32'h0; addr = 32'h0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL abort_in_wait: busy=%b req=%b expected 1/0", busy, mem_req);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_req, busy, done, err} !== 4'b0000 || mem_addr !== 32'h0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_async_clear: req=%b busy=%b done=%b err=%b data=%h expected zeros",
               mem_req, busy, done, err, rd_data);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = WORD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({mem_req, busy, done, err} !== 4'b0000 || mem_addr !== 32'h0 || rd_data !== 32'h0) leak = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (leak) begin
      errors++; $display("FAIL abort_late_rvalid: outputs=%b%b%b%b data=%h expected zeros",
                         mem_req, busy, done, err, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_errors();
    test_stall();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_data_unit.md
LOAD_DATA_UNIT -- requirements
Module: load_data_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  load issue strobe, sampled in IDLE only.
REQ-005 inst  input  32  instruction; opcode inst[6:0], funct3 inst[14:12].
REQ-006 addr  input  32  effective byte address (rs1 + imm).
REQ-007 mem_req  output  1  data-memory read request.
REQ-008 mem_addr  output  32  word-aligned read address {addr[31:2],2'b00}.
REQ-009 mem_gnt  input  1  memory accepts request this cycle.
REQ-010 mem_rdata  input  32  read word, little-endian byte lanes.
REQ-011 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 rd_data  output  32  extracted, extended load result.
REQ-015 err  output  1  misaligned or illegal-funct3 flag, valid with done.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, DONE; 2-bit encoded, registered.
REQ-017 IDLE: start=1 with opcode 0000011 SHALL latch funct3 and addr, then go to REQ; start with any other opcode SHALL be ignored.
REQ-018 At acceptance, an illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=00 SHALL go directly to DONE with err=1 and rd_data=0, and no mem_req.
REQ-019 REQ: mem_req=1 and mem_addr from the latched addr, held stable until mem_gnt=1; on gnt go to WAIT.
REQ-020 WAIT: mem_req=0; mem_rvalid SHALL be ignored outside WAIT; on mem_rvalid, register the result and go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; err=0 for valid loads.
REQ-022 Byte select, off = latched addr[1:0]: byte = mem_rdata[8*off+7:8*off]; half = mem_rdata[16*addr[1]+15:16*addr[1]].
REQ-023 LB (000) sign-extends byte; LBU (100) zero-extends byte.
REQ-024 LH (001) sign-extends half; LHU (101) zero-extends half; LW (010) passes the word unchanged.
REQ-025 rd_data and err SHALL hold their values until the next DONE.
REQ-026 start while busy=1 SHALL be ignored; no queuing.
REQ-027 Minimum latency, with gnt in REQ and rvalid in the first WAIT cycle: done 3 cycles after the start edge.
REQ-028 Unbounded gnt/rvalid stalls SHALL be tolerated; no timeout.
REQ-029 mem_addr SHALL read 0 whenever mem_req=0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and mem_req=0, busy=0, done=0, err=0, rd_data=0, mem_addr=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it; a late mem_rvalid after release SHALL be ignored in IDLE.

Verification
REQ-032 LB, addr=0x1003, mem_rdata=0xA5F0B376 -> rd_data=0xFFFFFFA5, err=0, done 3 cycles after start.
REQ-033 LBU addr=0x1000 -> 0x00000076; LHU addr=0x1000 -> 0x0000B376; LH addr=0x1002 -> 0xFFFFA5F0; LW addr=0x1000 -> 0xA5F0B376.
REQ-034 LW addr=0x1002 -> mem_req never asserted, done next cycle, err=1, rd_data=0.
REQ-035 mem_gnt low for 4 cycles, then rvalid 2 cycles after gnt -> mem_addr stable throughout, single done pulse, correct data.
REQ-036 rst_n pulsed low in WAIT, then rvalid -> no done, busy=0, all outputs 0.
REQ-037 start asserted while busy, and start with opcode 0100011 in IDLE -> both ignored; no second transaction.
